// File: rtl/rom_scan_decoder.sv
// Boot-time ROM validator: walks every ROM word, skips empty markers and streams
// each remaining word with its byte address and decoder illegal flag, keeping scan statistics.
module rom_scan_decoder #(
    parameter int          ADDR_WIDTH    = 8,
    parameter int          READ_LATENCY  = 0,
    parameter logic [31:0] EMPTY_WORD    = 32'hFFFF_FFFF,
    parameter bit          STOP_ON_ERROR = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [31:0]           rom_data,
    output logic [31:0]           dec_word,
    input  logic                  dec_error,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] out_byte_addr,
    output logic [31:0]           out_word,
    output logic                  out_illegal,
    output logic                  busy,
    output logic                  done,
    output logic                  halted_on_error,
    output logic [ADDR_WIDTH:0]   count_emitted,
    output logic [ADDR_WIDTH:0]   count_illegal,
    output logic [ADDR_WIDTH:0]   count_skipped
);

    localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WCW-1:0]        WAIT_LAST  = WCW'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_CHECK = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // With a combinational ROM there is nothing to wait for after an address change.
    localparam state_t SCAN_ENTRY = (READ_LATENCY == 0) ? S_CHECK : S_WAIT;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [WCW-1:0]        r_wait_cnt;
    logic [31:0]           r_out_word;
    logic                  r_out_illegal;
    logic [ADDR_WIDTH+1:0] r_out_byte_addr;
    logic                  r_halted;
    logic [ADDR_WIDTH:0]   r_count_emitted;
    logic [ADDR_WIDTH:0]   r_count_illegal;
    logic [ADDR_WIDTH:0]   r_count_skipped;

    logic w_start;
    logic w_empty;
    logic w_last;
    logic w_handshake;
    logic w_halt;
    logic w_advance;

    assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_empty     = (rom_data == EMPTY_WORD);
    assign w_last      = (r_index == LAST_INDEX);
    assign w_handshake = (r_state == S_EMIT) && out_ready;
    assign w_halt      = w_handshake && r_out_illegal && STOP_ON_ERROR;
    assign w_advance   = ((r_state == S_CHECK) && w_empty) || (w_handshake && !w_halt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_next = SCAN_ENTRY;
            end
            S_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (!w_empty)   w_state_next = S_EMIT;
                else if (w_last) w_state_next = S_DONE;
                else             w_state_next = SCAN_ENTRY;
            end
            S_EMIT: begin
                if (w_halt)                      w_state_next = S_DONE;
                else if (w_handshake && w_last)  w_state_next = S_DONE;
                else if (w_handshake)            w_state_next = SCAN_ENTRY;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_EMIT);
        done      = (r_state == S_DONE);
        busy      = (r_state == S_WAIT) || (r_state == S_CHECK) || (r_state == S_EMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_index         <= '0;
            r_wait_cnt      <= '0;
            r_out_word      <= '0;
            r_out_illegal   <= 1'b0;
            r_out_byte_addr <= '0;
            r_halted        <= 1'b0;
            r_count_emitted <= '0;
            r_count_illegal <= '0;
            r_count_skipped <= '0;
        end else begin
            if (w_start) begin
                r_index         <= '0;
                r_wait_cnt      <= '0;
                r_halted        <= 1'b0;
                r_count_emitted <= '0;
                r_count_illegal <= '0;
                r_count_skipped <= '0;
            end
            case (r_state)
                S_WAIT: r_wait_cnt <= r_wait_cnt + WCW'(1);
                S_CHECK: begin
                    if (w_empty) begin
                        r_count_skipped <= r_count_skipped + (ADDR_WIDTH+1)'(1);
                    end else begin
                        r_out_word      <= rom_data;
                        r_out_illegal   <= dec_error;
                        r_out_byte_addr <= {r_index, 2'b00};
                    end
                end
                S_EMIT: begin
                    if (w_handshake) begin
                        r_count_emitted <= r_count_emitted + (ADDR_WIDTH+1)'(1);
                        if (r_out_illegal) r_count_illegal <= r_count_illegal + (ADDR_WIDTH+1)'(1);
                    end
                    if (w_halt) r_halted <= 1'b1;
                end
                default: ;
            endcase
            if (w_advance && !w_last) begin
                r_index    <= r_index + ADDR_WIDTH'(1);
                r_wait_cnt <= '0;
            end
        end
    end

    assign rom_address     = r_index;
    assign dec_word        = rom_data;
    assign out_word        = r_out_word;
    assign out_illegal     = r_out_illegal;
    assign out_byte_addr   = r_out_byte_addr;
    assign halted_on_error = r_halted;
    assign count_emitted   = r_count_emitted;
    assign count_illegal   = r_count_illegal;
    assign count_skipped   = r_count_skipped;

endmodule

// File: tb/tb_rom_scan_decoder.sv
// Bench for rom_scan_decoder: three instances (plain, stop-on-error, read latency 2)
// share one ROM image; each scan is checked against a word-by-word reference model.
module tb_rom_scan_decoder;

    localparam int          AW    = 3;
    localparam int          NW    = 8;
    localparam int          NI    = 3;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    logic             start       [NI];
    logic             out_ready   [NI];
    logic [AW-1:0]    rom_address [NI];
    logic [AW-1:0]    addr_d1     [NI];
    logic [AW-1:0]    addr_d2     [NI];
    logic [31:0]      rom_data    [NI];
    logic [31:0]      dec_word    [NI];
    logic             dec_error   [NI];
    logic             out_valid   [NI];
    logic [AW+1:0]    out_byte_addr [NI];
    logic [31:0]      out_word    [NI];
    logic             out_illegal [NI];
    logic             busy        [NI];
    logic             done        [NI];
    logic             halted      [NI];
    logic [AW:0]      cnt_em      [NI];
    logic [AW:0]      cnt_il      [NI];
    logic [AW:0]      cnt_sk      [NI];
    logic [31:0]      rom_mem     [NW];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model results for the scan under test
    logic [AW+1:0] exp_addr [$];
    logic [31:0]   exp_word [$];
    bit            exp_ill  [$];
    int exp_em, exp_il, exp_sk, exp_cyc, exp_max_addr;
    bit exp_halt;

    always #5 clk = ~clk;

    function automatic bit is_illegal(input logic [31:0] w);
        return !(w[6:0] == 7'h13 || w[6:0] == 7'h33);
    endfunction

    function automatic int rl_of(input int inst);
        return (inst == 2) ? 2 : 0;
    endfunction

    function automatic bit stop_of(input int inst);
        return (inst == 1);
    endfunction

    // ROM with per-instance read latency, plus the external decoder
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            addr_d1[i] <= rom_address[i];
            addr_d2[i] <= addr_d1[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            rom_data[i]  = rom_mem[(rl_of(i) == 2) ? addr_d2[i] : rom_address[i]];
            dec_error[i] = is_illegal(dec_word[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            rom_scan_decoder #(
                .ADDR_WIDTH   (AW),
                .READ_LATENCY (gi == 2 ? 2 : 0),
                .EMPTY_WORD   (EMPTY),
                .STOP_ON_ERROR(gi == 1)
            ) u_dut (
                .clk            (clk),
                .reset          (reset),
                .start          (start[gi]),
                .rom_address    (rom_address[gi]),
                .rom_data       (rom_data[gi]),
                .dec_word       (dec_word[gi]),
                .dec_error      (dec_error[gi]),
                .out_valid      (out_valid[gi]),
                .out_ready      (out_ready[gi]),
                .out_byte_addr  (out_byte_addr[gi]),
                .out_word       (out_word[gi]),
                .out_illegal    (out_illegal[gi]),
                .busy           (busy[gi]),
                .done           (done[gi]),
                .halted_on_error(halted[gi]),
                .count_emitted  (cnt_em[gi]),
                .count_illegal  (cnt_il[gi]),
                .count_skipped  (cnt_sk[gi])
            );
        end
    endgenerate

    task automatic build_model(input int inst);
        int rl;
        rl = rl_of(inst);
        exp_addr.delete(); exp_word.delete(); exp_ill.delete();
        exp_em = 0; exp_il = 0; exp_sk = 0; exp_cyc = 0; exp_halt = 0; exp_max_addr = 0;
        for (int i = 0; i < NW; i++) begin
            exp_max_addr = i;
            if (rom_mem[i] == EMPTY) begin
                exp_sk++;
                exp_cyc += rl + 1;
            end else begin
                exp_addr.push_back((AW+2)'(i * 4));
                exp_word.push_back(rom_mem[i]);
                exp_ill.push_back(is_illegal(rom_mem[i]));
                exp_em++;
                if (is_illegal(rom_mem[i])) exp_il++;
                exp_cyc += rl + 2;
                if (is_illegal(rom_mem[i]) && stop_of(inst)) begin
                    exp_halt = 1;
                    break;
                end
            end
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: stall first record 5 cycles
    task automatic run_scan(input int inst, input int mode, input bit busy_starts, input string name);
        int cyc, first_valid, done_cyc, stall_left, max_addr, recs;
        bit fin, prev_valid, prev_ready;
        logic [AW+1:0] prev_addr;
        logic [31:0]   prev_word;
        logic          prev_ill;
        logic [AW:0]   prev_em;
        build_model(inst);
        @(posedge clk); #1;
        start[inst] = 1'b1;
        out_ready[inst] = 1'b1;
        @(posedge clk); #1;
        start[inst] = 1'b0;
        cyc = 0; first_valid = -1; done_cyc = -1; fin = 0; max_addr = 0; recs = 0;
        stall_left = (mode == 2) ? 5 : 0;
        prev_valid = 0; prev_ready = 0; prev_addr = '0; prev_word = '0; prev_ill = 0; prev_em = '0;
        for (int k = 0; k < 2000 && !fin; k++) begin
            if (mode == 1) out_ready[inst] = 1'($urandom_range(0, 1));
            else if (mode == 2 && stall_left > 0 && out_valid[inst]) begin
                out_ready[inst] = 1'b0;
                stall_left--;
            end else out_ready[inst] = 1'b1;
            start[inst] = busy_starts && busy[inst] && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (int'(rom_address[inst]) > max_addr) max_addr = int'(rom_address[inst]);
            if (prev_valid && !prev_ready) begin
                n_cmp++;
                if (out_valid[inst] !== 1'b1 || out_byte_addr[inst] !== prev_addr ||
                    out_word[inst] !== prev_word || out_illegal[inst] !== prev_ill ||
                    cnt_em[inst] !== prev_em) begin
                    n_bad++;
                    $display("FAIL %s stall_hold: got valid=%b addr=%h word=%h ill=%b em=%0d required valid=1 addr=%h word=%h ill=%b em=%0d",
                             name, out_valid[inst], out_byte_addr[inst], out_word[inst], out_illegal[inst],
                             cnt_em[inst], prev_addr, prev_word, prev_ill, prev_em);
                end
            end
            if (out_valid[inst] && first_valid < 0) first_valid = cyc;
            if (done[inst]) begin
                fin = 1;
                done_cyc = cyc;
            end else if (out_valid[inst] && out_ready[inst]) begin
                n_cmp++;
                if (exp_addr.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s extra_record: got addr=%h word=%h required no record",
                             name, out_byte_addr[inst], out_word[inst]);
                end else begin
                    if (out_byte_addr[inst] !== exp_addr[0] || out_word[inst] !== exp_word[0] ||
                        out_illegal[inst] !== exp_ill[0]) begin
                        n_bad++;
                        $display("FAIL %s record%0d: got addr=%h word=%h ill=%b required addr=%h word=%h ill=%b",
                                 name, recs, out_byte_addr[inst], out_word[inst], out_illegal[inst],
                                 exp_addr[0], exp_word[0], exp_ill[0]);
                    end
                    void'(exp_addr.pop_front()); void'(exp_word.pop_front()); void'(exp_ill.pop_front());
                end
                recs++;
            end
            prev_valid = out_valid[inst]; prev_ready = out_ready[inst];
            prev_addr = out_byte_addr[inst]; prev_word = out_word[inst];
            prev_ill = out_illegal[inst]; prev_em = cnt_em[inst];
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start[inst] = 1'b0;
        out_ready[inst] = 1'b1;
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL %s timeout: got done=0 after %0d cycles required done=1", name, cyc);
        end
        n_cmp++;
        if (exp_addr.size() != 0) begin
            n_bad++;
            $display("FAIL %s missing_records: got %0d records required %0d more", name, recs, exp_addr.size());
        end
        n_cmp++;
        if (cnt_em[inst] !== (AW+1)'(exp_em) || cnt_il[inst] !== (AW+1)'(exp_il) ||
            cnt_sk[inst] !== (AW+1)'(exp_sk)) begin
            n_bad++;
            $display("FAIL %s counts: got em=%0d il=%0d sk=%0d required em=%0d il=%0d sk=%0d",
                     name, cnt_em[inst], cnt_il[inst], cnt_sk[inst], exp_em, exp_il, exp_sk);
        end
        n_cmp++;
        if (halted[inst] !== exp_halt || busy[inst] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s halt_busy: got halted=%b busy=%b required halted=%b busy=0",
                     name, halted[inst], busy[inst], exp_halt);
        end
        n_cmp++;
        if (max_addr != exp_max_addr) begin
            n_bad++;
            $display("FAIL %s max_rom_address: got %0d required %0d", name, max_addr, exp_max_addr);
        end
        if (mode == 0) begin
            n_cmp++;
            if (done_cyc != exp_cyc) begin
                n_bad++;
                $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_cyc);
            end
            if (rom_mem[0] != EMPTY) begin
                n_cmp++;
                if (first_valid != rl_of(inst) + 1) begin
                    n_bad++;
                    $display("FAIL %s first_valid_cycle: got %0d required %0d", name, first_valid, rl_of(inst) + 1);
                end
            end
        end
        $display("scan %s inst=%0d records=%0d em=%0d il=%0d sk=%0d halted=%b cycles=%0d",
                 name, inst, recs, cnt_em[inst], cnt_il[inst], cnt_sk[inst], halted[inst], done_cyc);
    endtask

    task automatic check_idle(input int inst, input string name);
        n_cmp++;
        if (out_valid[inst] !== 1'b0 || busy[inst] !== 1'b0 || done[inst] !== 1'b0 ||
            halted[inst] !== 1'b0 || rom_address[inst] !== '0 || out_word[inst] !== '0 ||
            out_byte_addr[inst] !== '0 || out_illegal[inst] !== 1'b0 ||
            cnt_em[inst] !== '0 || cnt_il[inst] !== '0 || cnt_sk[inst] !== '0) begin
            n_bad++;
            $display("FAIL %s inst%0d: got valid=%b busy=%b done=%b halt=%b addr=%0d word=%h baddr=%h ill=%b em=%0d il=%0d sk=%0d required all zero",
                     name, inst, out_valid[inst], busy[inst], done[inst], halted[inst], rom_address[inst],
                     out_word[inst], out_byte_addr[inst], out_illegal[inst], cnt_em[inst], cnt_il[inst], cnt_sk[inst]);
        end
    endtask

    function automatic logic [31:0] legal_word();
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], 7'h13};
    endfunction

    task automatic load_basic();
        rom_mem[0] = 32'h0010_0093;
        rom_mem[1] = 32'h0020_8133;
        for (int i = 2; i < NW; i++) rom_mem[i] = EMPTY;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_idle(i, "reset_values");
        $display("reset check done");
    endtask

    task automatic test_basic();
        load_basic();
        run_scan(0, 0, 0, "basic");
    endtask

    task automatic test_stall();
        load_basic();
        run_scan(0, 2, 0, "stall");
    endtask

    task automatic test_illegal();
        load_basic();
        rom_mem[3] = 32'h0000_0000;
        run_scan(0, 0, 0, "illegal_continue");
        run_scan(1, 0, 0, "stop_on_error");
    endtask

    task automatic test_latency();
        for (int i = 0; i < NW; i++) rom_mem[i] = legal_word();
        run_scan(2, 0, 0, "latency2");
    endtask

    task automatic test_reset_mid_scan();
        int emits;
        bit hit;
        for (int i = 0; i < NW; i++) rom_mem[i] = legal_word();
        @(posedge clk); #1;
        start[0] = 1'b1; out_ready[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        emits = 0; hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            if (out_valid[0]) emits++;
            if (emits == 3) hit = 1;
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL reset_mid_scan third_emit: got %0d emits required 3", emits);
        end
        reset = 1'b1;
        out_ready[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_idle(i, "reset_mid_scan");
        run_scan(0, 1, 1, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < NW; i++) begin
                case ($urandom_range(0, 3))
                    0:       rom_mem[i] = EMPTY;
                    1:       rom_mem[i] = {rom_mem[i][31:7] ^ 25'($urandom), 7'h0B};
                    default: rom_mem[i] = legal_word();
                endcase
            end
            run_scan(t % NI, (t < 3) ? 0 : 1, (t >= 3), $sformatf("random%0d", t));
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            out_ready[i] = 1'b1;
        end
        for (int i = 0; i < NW; i++) rom_mem[i] = EMPTY;
        test_reset();
        test_basic();
        test_stall();
        test_illegal();
        test_latency();
        test_reset_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
